// File: rtl/uart_pkg.sv
// Shared constants and entry type for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int RXF_ENTRY_W = UART_DATA_W + 1;
  localparam int RXF_DEPTH   = 16;
  localparam int RXF_ADDR_W  = $clog2(RXF_DEPTH);
  localparam int RXF_THRESH  = 8;

  // One buffered byte plus its framing-error tag; err sits in the MSB.
  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } rxf_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the RX FIFO: synchronous write, asynchronous read, no reset.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH  = RXF_DEPTH,
  parameter int ADDR_W = RXF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [RXF_ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [RXF_ENTRY_W-1:0] rdata
);

  logic [RXF_ENTRY_W-1:0] mem [DEPTH];

  // Write port: one entry per accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART RX: edge-detects done, queues {err,data}
// entries, presents the head first-word-fall-through, flags overrun and
// raises a level-threshold interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = RXF_DEPTH,
  parameter int ADDR_W = RXF_ADDR_W,
  parameter int THRESH = RXF_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              rx_error,
  input  logic              pop,
  input  logic              flush,
  input  logic              clr_overrun,
  output logic [7:0]        rd_data,
  output logic              rd_err,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overrun,
  output logic              irq
);

  localparam logic [ADDR_W:0]   LVL_DEPTH  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_THRESH = (ADDR_W+1)'(THRESH);
  localparam logic [ADDR_W:0]   LVL_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic              done_q;
  // Low for the first cycle out of reset so a done held across reset
  // release is never mistaken for a fresh edge.
  logic              armed;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic              push;
  logic              pop_ok;
  logic              push_ok;
  logic              we;
  logic              ovr_new;
  logic [ADDR_W:0]   level_nxt;

  rxf_entry_t              wr_entry;
  rxf_entry_t              head;
  logic [RXF_ENTRY_W-1:0]  ram_rdata;

  assign wr_entry = '{err: rx_error, data: rx_data};
  assign head     = rxf_entry_t'(ram_rdata);

  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Event arbitration: flush beats everything; push into a full FIFO only
  // lands when a same-cycle pop frees the slot, otherwise it is an overrun.
  always_comb begin
    push      = rx_done & ~done_q & armed;
    pop_ok    = pop & ~empty;
    push_ok   = push & (~full | pop_ok);
    we        = push_ok & ~flush;
    ovr_new   = push & full & ~pop_ok & ~flush;
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   level_nxt = level + LVL_ONE;
        2'b01:   level_nxt = level - LVL_ONE;
        default: level_nxt = level;
      endcase
    end
  end

  // Pointers, level, status flags, sticky overrun and irq.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q  <= 1'b0;
      armed   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      overrun <= 1'b0;
      irq     <= 1'b0;
    end else begin
      done_q <= rx_done;
      armed  <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (we) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LVL_DEPTH);
      irq   <= (level_nxt >= LVL_THRESH);
      if (ovr_new) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  // Head entry, forced to zero while the FIFO is empty.
  always_comb begin
    rd_data = 8'h00;
    rd_err  = 1'b0;
    if (!empty) begin
      rd_data = head.data;
      rd_err  = head.err;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int THRESH = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_done = 1'b0;
  logic            rx_error = 1'b0;
  logic            pop = 1'b0;
  logic            flush = 1'b0;
  logic            clr_overrun = 1'b0;
  logic [7:0]      rd_data;
  logic            rd_err;
  logic            empty;
  logic            full;
  logic [ADDR_W:0] level;
  logic            overrun;
  logic            irq;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .THRESH (THRESH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_error    (rx_error),
    .pop         (pop),
    .flush       (flush),
    .clr_overrun (clr_overrun),
    .rd_data     (rd_data),
    .rd_err      (rd_err),
    .empty       (empty),
    .full        (full),
    .level       (level),
    .overrun     (overrun),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {err,data}, a sticky lost-byte flag and
  // the previous done value. A done seen on the first cycle after reset
  // release never counts as a new byte.
  logic [8:0] mq[$];
  bit         m_ovr = 0;
  bit         m_dq = 0;
  bit         m_was_rst = 1;
  bit         m_push;
  bit         m_lost;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_ovr     = 0;
      m_dq      = 0;
      m_was_rst = 1;
    end else begin
      m_push    = rx_done && !m_dq && !m_was_rst;
      m_dq      = rx_done;
      m_was_rst = 0;
      m_lost    = 0;
      if (flush) begin
        mq.delete();
      end else begin
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (m_push) begin
          if (mq.size() < DEPTH) mq.push_back({rx_error, rx_data});
          else m_lost = 1;
        end
      end
      if (m_lost) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_level",   32'(level),   32'(mq.size()));
      chk("m_empty",   32'(empty),   32'(mq.size() == 0));
      chk("m_full",    32'(full),    32'(mq.size() == DEPTH));
      chk("m_irq",     32'(irq),     32'(mq.size() >= THRESH));
      chk("m_overrun", 32'(overrun), 32'(m_ovr));
      chk("m_rd_data", 32'(rd_data), (mq.size() > 0) ? 32'(mq[0][7:0]) : 32'h0);
      chk("m_rd_err",  32'(rd_err),  (mq.size() > 0) ? 32'(mq[0][8])   : 32'h0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic e);
    @(negedge clk);
    rx_data  = d;
    rx_error = e;
    rx_done  = 1'b1;
    @(negedge clk);
    rx_done  = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] d, input logic e);
    chk(name, 32'(rd_data), 32'(d));
    chk({name, "_err"}, 32'(rd_err), 32'(e));
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovr",   32'(overrun), 32'd0);
    chk("rst_irq",   32'(irq), 32'd0);
    chk("rst_data",  32'(rd_data), 32'h00);

    // Single byte with done held for three cycles
    tick();
    rx_data = 8'hA5; rx_error = 1'b0; rx_done = 1'b1;
    repeat (3) tick();
    rx_done = 1'b0;
    chk("single_level", 32'(level), 32'd1);
    chk("single_data",  32'(rd_data), 32'hA5);
    pop_chk("single_pop", 8'hA5, 1'b0);
    chk("single_empty", 32'(empty), 32'd1);

    // Fill, partial drain, wrap-around refill
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i), 1'b0);
      chk("fill_irq", 32'(irq), 32'((i + 1) >= 8));
    end
    chk("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) pop_chk("drain4", 8'(i), 1'b0);
    for (int i = 16; i < 20; i++) push_byte(8'(i), 1'b0);
    chk("wrap_full",  32'(full), 32'd1);
    chk("wrap_level", 32'(level), 32'd16);

    // Overrun, then clear racing a new overrun, then clear alone
    push_byte(8'h55, 1'b0);
    chk("ovr_set",   32'(overrun), 32'd1);
    chk("ovr_level", 32'(level), 32'd16);
    tick();
    rx_data = 8'hAA; rx_done = 1'b1; clr_overrun = 1'b1;
    tick();
    rx_done = 1'b0; clr_overrun = 1'b0;
    chk("ovr_clr_race", 32'(overrun), 32'd1);
    tick();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Full + push + pop
    chk("fpp_head", 32'(rd_data), 32'h04);
    rx_data = 8'h77; rx_done = 1'b1; pop = 1'b1;
    tick();
    rx_done = 1'b0; pop = 1'b0;
    chk("fpp_level", 32'(level), 32'd16);
    chk("fpp_ovr",   32'(overrun), 32'd0);
    for (int i = 5; i < 20; i++) begin
      pop_chk("drain_seq", 8'(i), 1'b0);
      chk("drain_irq", 32'(irq), 32'((16 - (i - 4)) >= 8));
    end
    pop_chk("drain_77", 8'h77, 1'b0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Empty + push + pop
    rx_data = 8'h3C; rx_done = 1'b1; pop = 1'b1;
    tick();
    rx_done = 1'b0; pop = 1'b0;
    chk("epp_level", 32'(level), 32'd1);
    chk("epp_data",  32'(rd_data), 32'h3C);
    pop_chk("epp_pop", 8'h3C, 1'b0);

    // Error tag
    push_byte(8'hC3, 1'b1);
    chk("err_tag",  32'(rd_err), 32'd1);
    chk("err_data", 32'(rd_data), 32'hC3);

    // Flush with a same-cycle push, overrun held set across it
    for (int i = 0; i < 15; i++) push_byte(8'(8'h20 + i), 1'b0);
    push_byte(8'hEE, 1'b0);
    chk("pre_flush_ovr", 32'(overrun), 32'd1);
    rx_data = 8'h96; rx_done = 1'b1; flush = 1'b1;
    tick();
    rx_done = 1'b0; flush = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovr",   32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;

    // Reset while done is held high
    rx_data = 8'h5A; rx_done = 1'b1;
    tick();
    tick();
    chk("prerst_level", 32'(level), 32'd1);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("postrst_level", 32'(level), 32'd0);
    chk("postrst_empty", 32'(empty), 32'd1);
    rx_done = 1'b0;
    tick();
    push_byte(8'h81, 1'b0);
    pop_chk("postrst_pop", 8'h81, 1'b0);
    chk("end_empty", 32'(empty), 32'd1);

    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
